// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH-bit operands summed LSB-first through one full-adder cell.
// Optional subtract mode is enabled with SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             busy_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_shift;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic             sum_bit;
    logic             carry_bit;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] b_cap;
    logic             c_cap;

    // Single full-adder cell fed from the operand LSBs and the carry register
    always_comb begin
        sum_bit   = ra[0] ^ rb[0] ^ c;
        carry_bit = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    end

    always_comb begin
        last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
        accept   = start && ((state == IDLE) || (state == DONE));
    end

    // Sum bits enter at the MSB so the LSB-first stream ends up in place
    if (WIDTH == 1) begin : g_acc_w1
        assign acc_shift = sum_bit;
    end else begin : g_acc_wn
        assign acc_shift = {sum_bit, acc[WIDTH-1:1]};
    end

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; cin is ignored in this mode
    always_comb begin
        b_cap = sub ? ~b : b;
        c_cap = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_cap = b;
        c_cap = cin;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status flags are decoded from the upcoming state and then registered
    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        if (next_state == RUN) begin
            busy_nxt = 1'b1;
        end
        if (next_state == DONE) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            acc  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            s    <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            ra   <= a;
            rb   <= b_cap;
            acc  <= '0;
            c    <= c_cap;
            cnt  <= '0;
        end else if (state == RUN) begin
            ra   <= ra >> 1;
            rb   <= rb >> 1;
            acc  <= acc_shift;
            c    <= carry_bit;
            cnt  <= cnt + CNT_W'(1);
            // Outputs only ever see the completed result
            if (last_bit) begin
                s    <= acc_shift;
                cout <= carry_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=8), with
// hand-written sequences for reset, ignored start and back-to-back runs.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    vec_t vecs[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add_vec(input logic [7:0] va, input logic [7:0] vb, input logic vcin,
                           input logic vsub, input logic [7:0] es, input logic ec);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vcin; v.sub = vsub; v.es = es; v.ec = ec;
        vecs.push_back(v);
    endtask

    // Pulse start for one cycle and wait (bounded) for done
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vcin,
                          input logic vsub, output logic [7:0] rs, output logic rc,
                          output int lat, output int bcnt);
        a = va; b = vb; cin = vcin;
`ifdef SERIAL_ADDER_SUB_EN
        sub = vsub;
`else
        if (vsub) cin = vcin;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            tick();
            lat++;
        end
        rs = s;
        rc = cout;
    endtask

    logic [7:0] rs, s1, s2, ds;
    logic       rc, dcout;
    int         lat, bcnt, n, d1, d2, dn, dc, consec;
    logic       prev_done;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_s", 32'(s), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        add_vec(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);
        add_vec(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1);
        add_vec(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        add_vec(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
        add_vec(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
        add_vec(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
        add_vec(8'h7F, 8'h7F, 1'b0, 1'b0, 8'hFE, 1'b0);
        add_vec(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
        add_vec(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
        add_vec(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
        add_vec(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
        add_vec(8'h07, 8'h05, 1'b0, 1'b0, 8'h0C, 1'b0);
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, lat, bcnt);
            check($sformatf("v%0d_s", i), 32'(rs), 32'(vecs[i].es));
            check($sformatf("v%0d_cout", i), 32'(rc), 32'(vecs[i].ec));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd8);
            tick();
            check($sformatf("v%0d_done_single", i), 32'(done), 32'd0);
            check($sformatf("v%0d_s_hold", i), 32'(s), 32'(vecs[i].es));
        end

        // Reset in the 4th RUN cycle aborts and clears the outputs
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        dc = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1) dc++;
        end
        check("midrst_no_done", 32'(dc), 32'd0);

        // Reset and start together: reset wins
        rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        tick();
        check("rst_start_idle", 32'(busy), 32'd0);

        run_op(8'h80, 8'h80, 1'b0, 1'b0, rs, rc, lat, bcnt);
        check("post_rst_s", 32'(rs), 32'h00);
        check("post_rst_cout", 32'(rc), 32'd1);
        check("post_rst_latency", 32'(lat), 32'd8);
        tick();

        // start and new operands during RUN are ignored
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 8'hAA; b = 8'h55; start = 1'b1;
        tick();
        start = 1'b0; a = 8'h00; b = 8'h00;
        dc = 0; dn = -1; ds = '0; dcout = 1'b1;
        for (int k = 3; k <= 20; k++) begin
            tick();
            if (done === 1'b1) begin
                dc++;
                if (dn < 0) begin
                    dn = k; ds = s; dcout = cout;
                end
            end
        end
        check("ignore_done_count", 32'(dc), 32'd1);
        check("ignore_latency", 32'(dn), 32'd8);
        check("ignore_s", 32'(ds), 32'h46);
        check("ignore_cout", 32'(dcout), 32'd0);

        // Back-to-back with start held high
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        a = 8'h7F; b = 8'h01;
        n = 0; d1 = -1; d2 = -1; s1 = '0; s2 = '0; consec = 0; prev_done = 1'b0;
        while (d2 < 0 && n < 40) begin
            tick();
            n++;
            if (done === 1'b1 && prev_done) consec++;
            prev_done = (done === 1'b1);
            if (done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = n; s1 = s;
                end else begin
                    d2 = n; s2 = s; start = 1'b0;
                end
            end
        end
        check("b2b_first_latency", 32'(d1), 32'd8);
        check("b2b_first_s", 32'(s1), 32'h02);
        check("b2b_second_latency", 32'(d2), 32'd17);
        check("b2b_second_s", 32'(s2), 32'h80);
        check("b2b_spacing", 32'(d2 - d1), 32'd9);
        check("b2b_no_consec_done", 32'(consec), 32'd0);
        tick();
        check("b2b_back_idle_busy", 32'(busy), 32'd0);
        check("b2b_back_idle_done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

- Bit-serial adder for the CMOS full-adder datapath: two WIDTH-bit operands enter in parallel and pass LSB-first through a single internal one-bit full-adder cell, one bit per clock, with a registered carry.
- Sits directly upstream of the full-adder stage and is the sequential driver for the `a`, `b`, `cin` → `s`, `cout` cell.
- Returns a WIDTH-bit sum and carry-out with a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range is WIDTH ≥ 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a new operation; sampled only in IDLE or DONE.
- `a` in WIDTH: operand A; captured on the accepted `start` edge.
- `b` in WIDTH: operand B; captured on the accepted `start` edge.
- `cin` in 1: carry-in; captured on the accepted `start` edge.
- `sub` in 1: present only when SERIAL_ADDER_SUB_EN is defined; selects subtraction; captured with `start`.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse; result valid.
- `s` out WIDTH: registered sum; held stable until the next completion.
- `cout` out 1: registered final carry-out; held with `s`.

## Operation
- States: IDLE, RUN, DONE. Internal registers: operand shift registers `ra`/`rb`, accumulator `acc`, carry `c`, bit counter `cnt` (width clog2(WIDTH+1)).
- IDLE → RUN on `start`=1:
  - `ra`←`a`, `rb`←`b`, `c`←`cin`, `cnt`←0, `acc`←0.
- RUN, each edge:
  - Full-add `ra[0]`, `rb[0]` and `c`.
  - Shift the sum bit into `acc` from the MSB side (LSB-first fill).
  - `c`←carry, shift `ra`/`rb` right by 1, `cnt`←`cnt`+1.
- RUN → DONE on the edge processing bit WIDTH-1 (`cnt`==WIDTH-1).
  - On that same edge, load `s` with the final `acc` value, including the last bit, and load `cout` with the final carry.
- DONE → RUN if `start`=1; this is a back-to-back capture identical to IDLE. Otherwise DONE → IDLE.
- `start` in RUN is ignored. Operands presented during RUN are not captured and do not affect the result.
- `s`/`cout` change only on the edge entering DONE. Partial sums are never visible on the outputs.
- Arithmetic: {`cout`,`s`} = `a` + `b` + `cin`, exact over WIDTH+1 bits. No overflow flag.
- WIDTH=1: RUN lasts exactly one cycle (`cnt`==0 is the last bit).

## Timing
- Reset values (edge with `rst`=1): state IDLE, `busy`=0, `done`=0, `s`=0, `cout`=0. Internal registers are cleared.
- Latency: `start` accepted at edge E0.
  - `busy`=1 from E0 through E_WIDTH.
  - `done`=1 and `s`/`cout` valid from edge E_WIDTH until E_WIDTH+1.
- Throughput:
  - With `start` held through DONE (back-to-back): one result per WIDTH+1 cycles.
  - With a return to IDLE: minimum WIDTH+2 cycles.
- `rst` mid-RUN aborts the operation: no `done`, and `s`/`cout` are zeroed. The next `start` after reset deasserts behaves normally.
- `rst` and `start` asserted together: reset wins and the operation is not accepted.
- `done` is never asserted for two consecutive cycles. A back-to-back operation gives `done`=0 for WIDTH cycles between pulses.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - Adds the `sub` port.
  - If `sub`=1 at capture: `rb`←~`b`, `c`←1, `cin` ignored, so `s` = `a`−`b` mod 2^WIDTH and `cout` = 1 iff `a` ≥ `b` (no borrow).
  - If `sub`=0: behaviour is identical to add.
- Not defined: no `sub` port; the block is add-only and all logic for inversion is absent.

## Test plan
- WIDTH=8, `a`=8'h0F, `b`=8'h01, `cin`=0, `start` 1 cycle → `done` pulse exactly 8 edges after the capture edge; `s`=8'h10, `cout`=0; `busy` high for 8 cycles.
- `a`=8'hFF, `b`=8'h01, `cin`=1 → `s`=8'h01, `cout`=1. Also run `a`=`b`=8'h00, `cin`=0 → `s`=8'h00, `cout`=0.
- Start `a`=8'h12, `b`=8'h34, then pulse `start` with `a`=8'hAA, `b`=8'h55 during RUN → result `s`=8'h46, `cout`=0; only one `done`.
- Assert `rst` in the 4th RUN cycle → `busy`/`done`/`s`/`cout` = 0 next cycle, no `done`. Then `a`=8'h80, `b`=8'h80 → `s`=8'h00, `cout`=1.
- Hold `start` high continuously with operands 8'h01+8'h01, then 8'h7F+8'h01 → `done` pulses 9 cycles apart with `s`=8'h02, then 8'h80.
- With SERIAL_ADDER_SUB_EN, `sub`=1, `a`=8'h05, `b`=8'h07 → `s`=8'hFE, `cout`=0. Then `a`=8'h07, `b`=8'h05 → `s`=8'h02, `cout`=1.
